data_mem_responder: RTL and testbench

//  Responder end of the core's load/store port: a word-organised data RAM behind a

---
 rtl/data_mem_responder.sv | 208 ++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Load/store responder: word-organised data RAM behind valid/ready request and
// response channels, with programmable wait states and access-error reporting.
module data_mem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int DEPTH_WORDS = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [IDX_W-1:0]  word_idx;
  logic [1:0]        lane;
  logic [MEM_AW-1:0] mem_addr;
  logic              range_err;
  logic              illegal_f3;
  logic              misaligned;
  logic              acc_err;
  logic              is_half;
  logic              is_word;
  logic [DATA_W-1:0] rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [DATA_W-1:0] load_data;
  logic [3:0]        wr_be;
  logic [DATA_W-1:0] wr_data;
  logic              access_now;
  logic              mem_we;

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  assign word_idx = addr_q[ADDR_W-1:2];
  assign lane     = addr_q[1:0];
  assign mem_addr = word_idx[MEM_AW-1:0];

  // Error classification of the captured request
  always_comb begin
    range_err  = ({{(32-IDX_W){1'b0}}, word_idx} >= 32'(DEPTH_WORDS));
    is_half    = (funct3_q[1:0] == 2'b01);
    is_word    = (funct3_q[1:0] == 2'b10);
    if (write_q) begin
      illegal_f3 = funct3_q[2] || (funct3_q[1:0] == 2'b11);
    end else begin
      illegal_f3 = (funct3_q[1:0] == 2'b11) || (funct3_q == 3'b110);
    end
    misaligned = (is_half && lane[0]) || (is_word && (lane != 2'b00));
    acc_err    = range_err || illegal_f3 || misaligned;
  end

  always_comb begin
    rd_word = range_err ? '0 : mem[mem_addr];
    case (lane)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    // funct3[2] selects zero extension for byte and half loads
    case (funct3_q[1:0])
      2'b00:   load_data = {{24{rd_byte[7] & ~funct3_q[2]}}, rd_byte};
      2'b01:   load_data = {{16{rd_half[15] & ~funct3_q[2]}}, rd_half};
      2'b10:   load_data = rd_word;
      default: load_data = '0;
    endcase
  end

  // Replicate store data across lanes so the byte enables pick the right slice
  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << lane;
        wr_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wr_be   = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        wr_be   = 4'b1111;
        wr_data = wdata_q;
      end
      default: begin
        wr_be   = 4'b0000;
        wr_data = '0;
      end
    endcase
  end

  assign access_now = (state_q == S_WAIT) && (cnt_q == '0);
  assign mem_we     = access_now && write_q && !acc_err && !reset;

  // RAM is deliberately outside the reset domain so its contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem[mem_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    funct3_d    = funct3_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          addr_d   = req_addr;
          funct3_d = req_funct3;
          wdata_d  = req_wdata;
          cnt_d    = CNT_W'(WAIT_CYCLES);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rsp_rdata_d = (write_q || acc_err) ? '0 : load_data;
          rsp_err_d   = acc_err;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      funct3_q    <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      funct3_q    <= funct3_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: instance a (2 wait states, 64 words)
// and instance b (no wait states, 128 words) share stimulus through a selector.
module tb_data_mem_responder;

  localparam int WAIT_A  = 2;
  localparam int DEPTH_A = 64;
  localparam int WAIT_B  = 0;
  localparam int DEPTH_B = 128;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        req_valid;
  logic        req_write;
  logic [8:0]  req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  logic        ready_a, valid_a, err_a;
  logic        ready_b, valid_b, err_b;
  logic [31:0] rdata_a, rdata_b;

  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  always #5 clk = ~clk;

  assign req_ready = sel ? ready_b : ready_a;
  assign rsp_valid = sel ? valid_b : valid_a;
  assign rsp_rdata = sel ? rdata_b : rdata_a;
  assign rsp_err   = sel ? err_b   : err_a;

  data_mem_responder #(.DATA_W(32), .ADDR_W(9), .DEPTH_WORDS(DEPTH_A), .WAIT_CYCLES(WAIT_A)) u_dut_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid && !sel), .req_ready(ready_a), .req_write(req_write),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(valid_a), .rsp_ready(rsp_ready), .rsp_rdata(rdata_a), .rsp_err(err_a)
  );

  data_mem_responder #(.DATA_W(32), .ADDR_W(9), .DEPTH_WORDS(DEPTH_B), .WAIT_CYCLES(WAIT_B)) u_dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid && sel), .req_ready(ready_b), .req_write(req_write),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(valid_b), .rsp_ready(rsp_ready), .rsp_rdata(rdata_b), .rsp_err(err_b)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_a[DEPTH_A];
  logic [31:0] model_b[DEPTH_B];
  int          checks   = 0;
  int          failures = 0;

  // Reference model of one access; updates the shadow RAM on a legal store
  task automatic model_access(input logic s, input logic wr, input logic [8:0] addr,
                              input logic [2:0] f3, input logic [31:0] wd,
                              output logic [31:0] rd, output logic er);
    int          depth, idx, ln;
    logic [31:0] word;
    logic [7:0]  b;
    logic [15:0] h;
    depth = s ? DEPTH_B : DEPTH_A;
    idx   = int'(addr[8:2]);
    ln    = int'(addr[1:0]);
    er    = (idx >= depth);
    if (wr) begin
      if (!(f3 inside {3'b000, 3'b001, 3'b010})) er = 1'b1;
    end else begin
      if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) er = 1'b1;
    end
    if ((f3 == 3'b001 || f3 == 3'b101) && addr[0]) er = 1'b1;
    if (f3 == 3'b010 && ln != 0) er = 1'b1;
    word = 32'h0;
    if (!er) word = s ? model_b[idx] : model_a[idx];
    rd = 32'h0;
    if (!er && wr) begin
      case (f3)
        3'b000:  word[ln*8 +: 8]  = wd[7:0];
        3'b001:  word[ln*8 +: 16] = wd[15:0];
        default: word = wd;
      endcase
      if (s) model_b[idx] = word;
      else   model_a[idx] = word;
    end else if (!er) begin
      b = word[ln*8 +: 8];
      h = word[ln*8 +: 16];
      case (f3)
        3'b000:  rd = {{24{b[7]}}, b};
        3'b100:  rd = {24'h0, b};
        3'b001:  rd = {{16{h[15]}}, h};
        3'b101:  rd = {16'h0, h};
        default: rd = word;
      endcase
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic issue(input logic s, input logic wr, input logic [8:0] addr,
                       input logic [2:0] f3, input logic [31:0] wd, input bit expect_rsp);
    exp_t e;
    int   n;
    sel = s;
    #1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL issue_timeout req_ready=%b required=1", req_ready);
    end
    req_write  = wr;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wd;
    req_valid  = 1'b1;
    if (expect_rsp) begin
      model_access(s, wr, addr, f3, wd, e.rdata, e.err);
      sb_q.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic collect(input string name, input int exp_lat);
    exp_t e;
    int   k;
    k = 0;
    while (!rsp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!rsp_valid || sb_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL %s_timeout rsp_valid=%b queued=%0d required valid with entry", name, rsp_valid, sb_q.size());
      if (sb_q.size() != 0) void'(sb_q.pop_front());
      return;
    end
    e = sb_q.pop_front();
    checks++;
    if (rsp_rdata !== e.rdata) begin
      failures++;
      $display("[TB] FAIL %s_rdata got=%h required=%h", name, rsp_rdata, e.rdata);
    end
    checks++;
    if (rsp_err !== e.err) begin
      failures++;
      $display("[TB] FAIL %s_err got=%b required=%b", name, rsp_err, e.err);
    end
    if (exp_lat >= 0) begin
      checks++;
      if (k !== exp_lat) begin
        failures++;
        $display("[TB] FAIL %s_latency got=%0d required=%0d", name, k, exp_lat);
      end
    end
    @(negedge clk);
  endtask

  task automatic transact(input string name, input logic s, input logic wr, input logic [8:0] addr,
                          input logic [2:0] f3, input logic [31:0] wd);
    issue(s, wr, addr, f3, wd, 1'b1);
    collect(name, s ? WAIT_B + 1 : WAIT_A + 1);
  endtask

  task automatic test_reset;
    reset      = 1'b1;
    sel        = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_funct3 = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({ready_a, valid_a, err_a, rdata_a} !== {3'b100, 32'h0}) begin
      failures++;
      $display("[TB] FAIL reset_a ready/valid/err=%b%b%b rdata=%h required 100 and 0", ready_a, valid_a, err_a, rdata_a);
    end
    checks++;
    if ({ready_b, valid_b, err_b, rdata_b} !== {3'b100, 32'h0}) begin
      failures++;
      $display("[TB] FAIL reset_b ready/valid/err=%b%b%b rdata=%h required 100 and 0", ready_b, valid_b, err_b, rdata_b);
    end
  endtask

  task automatic test_loads;
    transact("sw_010",  1'b0, 1'b1, 9'h010, 3'b010, 32'hDEADBEEF);
    transact("lw_010",  1'b0, 1'b0, 9'h010, 3'b010, 32'h0);
    transact("lb_013",  1'b0, 1'b0, 9'h013, 3'b000, 32'h0);
    transact("lbu_013", 1'b0, 1'b0, 9'h013, 3'b100, 32'h0);
    transact("lh_012",  1'b0, 1'b0, 9'h012, 3'b001, 32'h0);
    transact("lhu_010", 1'b0, 1'b0, 9'h010, 3'b101, 32'h0);
  endtask

  task automatic test_partial_stores;
    transact("sb_011",   1'b0, 1'b1, 9'h011, 3'b000, 32'hFFFFFF55);
    transact("lw_after_sb", 1'b0, 1'b0, 9'h010, 3'b010, 32'h0);
    transact("sh_012",   1'b0, 1'b1, 9'h012, 3'b001, 32'hFFFF1234);
    transact("lw_after_sh", 1'b0, 1'b0, 9'h010, 3'b010, 32'h0);
  endtask

  task automatic test_errors;
    transact("err_lw_012",   1'b0, 1'b0, 9'h012, 3'b010, 32'h0);
    transact("err_sh_011",   1'b0, 1'b1, 9'h011, 3'b001, 32'h0000ABCD);
    transact("lw_after_sh_err", 1'b0, 1'b0, 9'h010, 3'b010, 32'h0);
    transact("err_ld_f3_011", 1'b0, 1'b0, 9'h010, 3'b011, 32'h0);
    transact("err_st_f3_110", 1'b0, 1'b1, 9'h010, 3'b110, 32'h01020304);
    transact("lw_after_st_f3", 1'b0, 1'b0, 9'h010, 3'b010, 32'h0);
    transact("err_lw_range", 1'b0, 1'b0, 9'h100, 3'b010, 32'h0);
    transact("lw_after_range", 1'b0, 1'b0, 9'h010, 3'b010, 32'h0);
  endtask

  task automatic test_backpressure;
    exp_t e;
    exp_t e2;
    int   k;
    rsp_ready = 1'b0;
    issue(1'b0, 1'b0, 9'h010, 3'b010, 32'h0, 1'b1);
    k = 0;
    while (!rsp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!rsp_valid || sb_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL bp_first_timeout rsp_valid=%b required=1", rsp_valid);
      rsp_ready = 1'b1;
      return;
    end
    e = sb_q.pop_front();
    req_write  = 1'b0;
    req_addr   = 9'h010;
    req_funct3 = 3'b100;
    req_wdata  = 32'h0;
    req_valid  = 1'b1;
    model_access(1'b0, 1'b0, 9'h010, 3'b100, 32'h0, e2.rdata, e2.err);
    sb_q.push_back(e2);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err || req_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bp_hold cycle=%0d valid=%b rdata=%h err=%b ready=%b required 1 %h %b 0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready, e.rdata, e.err);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_release valid=%b ready=%b required 0 1", rsp_valid, req_ready);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_accept ready=%b required=0", req_ready);
    end
    req_valid = 1'b0;
    collect("bp_second", WAIT_A + 1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL bp_single_accept cycle=%0d valid=%b ready=%b required 0 1", i, rsp_valid, req_ready);
      end
      @(negedge clk);
    end
  endtask

  // Seeds a known word, aborts a store with a reset pulse, then reads it back
  task automatic test_reset_abort(input logic s);
    transact(s ? "abort_seed_b" : "abort_seed_a", s, 1'b1, 9'h020, 3'b010, 32'h11223344);
    issue(s, 1'b1, 9'h020, 3'b010, 32'hA5A5A5A5, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < WAIT_A + 3; i++) begin
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL abort_no_rsp inst=%0d cycle=%0d valid=%b ready=%b required 0 1", s, i, rsp_valid, req_ready);
      end
      @(negedge clk);
    end
    transact(s ? "abort_check_b" : "abort_check_a", s, 1'b0, 9'h020, 3'b010, 32'h0);
  endtask

  task automatic test_back_to_back;
    transact("b2b_sw_b", 1'b1, 1'b1, 9'h044, 3'b010, 32'hCAFEF00D);
    transact("b2b_lh_b", 1'b1, 1'b0, 9'h046, 3'b001, 32'h0);
    transact("b2b_lb_b", 1'b1, 1'b0, 9'h045, 3'b000, 32'h0);
    transact("b2b_lw_b", 1'b1, 1'b0, 9'h044, 3'b010, 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_loads();
    test_partial_stores();
    test_errors();
    test_backpressure();
    test_reset_abort(1'b0);
    test_reset_abort(1'b1);
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
